mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one multiplier core between two front-end requesters: port 0 (SPI path,
//  fed from the SPI slave's received words) and port 1 (UART path). Arbitrates
//  round-robin, latches the operand pair, sequences the multiplier start/done
//  handshake with a watchdog timeout, and returns the result to the granted port.
// PARAMETERS
//  OP_WIDTH        16   operand width, bits
//  RES_WIDTH       32   result width, bits (= 2*OP_WIDTH)
//  TIMEOUT_CYCLES  255  max cycles in WAIT_DONE before error response (>=1)
// PORTS
//  clk          in   1          single system clock
//  reset        in   1          asynchronous, active-low reset
//  req0_valid   in   1          port 0 (SPI) has operand pair
//  req0_a/b     in   OP_WIDTH   port 0 operands
//  req0_ready   out  1          port 0 pair accepted this cycle (valid&ready)
//  req1_valid   in   1          port 1 (UART) has operand pair
//  req1_a/b     in   OP_WIDTH   port 1 operands
//  req1_ready   out  1          port 1 pair accepted this cycle
//  rsp0_valid   out  1          one-cycle pulse: response for port 0
//  rsp1_valid   out  1          one-cycle pulse: response for port 1
//  rsp_result   out  RES_WIDTH  result, held until next response
//  rsp_err      out  1          1 = timeout, rsp_result forced 0; held like rsp_result
//  mul_start    out  1          one-cycle start pulse to multiplier
//  mul_a/b      out  OP_WIDTH   registered operands, stable from start until done
//  mul_done     in   1          multiplier result valid (single-cycle pulse)
//  mul_result   in   RES_WIDTH  multiplier product, sampled on mul_done
//  busy         out  1          state != IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, all outputs 0, last_grant=1 (port 0 wins first tie).
//  - reqN_ready combinational: high only in IDLE for the granted port. Grant: only one
//    valid -> that port; both valid -> port != last_grant. Transfer cycle latches
//    mul_a/b, grant, updates last_grant, next state ISSUE.
//  - ISSUE: mul_start=1 for exactly one cycle; timeout counter cleared; -> WAIT_DONE.
//  - WAIT_DONE: counter increments each cycle. mul_done=1 -> capture mul_result into
//    rsp_result, rsp_err=0, -> RESPOND. Counter reaches TIMEOUT_CYCLES without done ->
//    rsp_result=0, rsp_err=1, -> RESPOND. Done and expiry same cycle: done wins.
//  - RESPOND: rspN_valid=1 one cycle for latched grant only; -> IDLE.
//  - Latency: accept cycle T -> mul_start at T+1 -> done at D -> rspN_valid at D+1.
//    Minimum accept-to-accept spacing 4 cycles (accept, ISSUE, done, RESPOND).
//  - mul_done outside WAIT_DONE ignored (late done after timeout must not create a
//    second response or alter rsp_result).
//  - Requester deasserting valid before ready: no transfer, no state change.
//  - Operand changes on req ports after accept have no effect.
//  - Reset mid-operation: immediate return to IDLE, no response emitted for the
//    in-flight request; mul_start low.
//  - Width: counter sized $clog2(TIMEOUT_CYCLES+1); no arithmetic on data path.
// STRUCTURE
//  - Package mult_ctrl_pkg: typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE,
//    RESPOND} arb_state_t; localparams OP_WIDTH/RES_WIDTH defaults; grant_t (1 bit).
//  - Sub-module rr_arbiter2: combinational 2-way round-robin grant from
//    {req1_valid, req0_valid} and last_grant; top holds FSM, latches, watchdog.
// TESTING
//  - Single port 0: a=0x0003,b=0x0005; model returns 0x0000000F 3 cycles after start
//    -> one mul_start, rsp0_valid pulse, rsp_result=0x0000000F, rsp_err=0, rsp1 never.
//  - Tie after reset: both valid same cycle -> port 0 granted first; keep both valid ->
//    second grant port 1, third port 0 (strict alternation).
//  - Timeout: TIMEOUT_CYCLES=8, model never asserts done -> rsp_err=1, rsp_result=0 on
//    cycle 9 after start; late mul_done afterward -> no extra rsp pulse.
//  - Done on expiry cycle: done arrives exactly at counter=TIMEOUT_CYCLES -> rsp_err=0,
//    result captured.
//  - Reset mid WAIT_DONE: drop reset -> busy=0, all outputs 0 asynchronously; release,
//    new port 1 request 0xFFFF*0xFFFF -> rsp_result=0xFFFE0001 on rsp1_valid.
//  - Operand stability: change req0_a after accept -> mul_a unchanged through done.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared types and default widths for the multiplier-sharing arbiter slice.
package mult_ctrl_pkg;

    localparam int OP_WIDTH  = 16;
    localparam int RES_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESPOND
    } arb_state_t;

    // 0 = port 0 (SPI path), 1 = port 1 (UART path)
    typedef logic grant_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request/response/multiplier bundle; the arbiter is the slave, the requesters and multiplier core sit on the master side.
interface mult_share_arbiter_if #(
    parameter int OP_WIDTH  = mult_ctrl_pkg::OP_WIDTH,
    parameter int RES_WIDTH = mult_ctrl_pkg::RES_WIDTH
);
    logic                 req0_valid;
    logic [OP_WIDTH-1:0]  req0_a;
    logic [OP_WIDTH-1:0]  req0_b;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [OP_WIDTH-1:0]  req1_a;
    logic [OP_WIDTH-1:0]  req1_b;
    logic                 req1_ready;
    logic                 rsp0_valid;
    logic                 rsp1_valid;
    logic [RES_WIDTH-1:0] rsp_result;
    logic                 rsp_err;
    logic                 mul_start;
    logic [OP_WIDTH-1:0]  mul_a;
    logic [OP_WIDTH-1:0]  mul_b;
    logic                 mul_done;
    logic [RES_WIDTH-1:0] mul_result;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
               mul_done, mul_result,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_err,
               mul_start, mul_a, mul_b
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
               mul_done, mul_result,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_err,
               mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational (zero latency).
// No backpressure of its own: a tie goes to the port that did not win last.
module rr_arbiter2
    import mult_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output logic       gnt_vld,
    output grant_t     gnt
);

    always_comb begin
        gnt_vld = |req;
        gnt     = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_grant;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multiplier between the SPI (port 0) and UART (port 1) requesters; response one cycle after mul_done.
// Requesters are held off (ready low) for the whole accept/issue/wait/respond sequence; a watchdog bounds the wait.
module mult_share_arbiter #(
    parameter int OP_WIDTH       = mult_ctrl_pkg::OP_WIDTH,
    parameter int RES_WIDTH      = mult_ctrl_pkg::RES_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    mult_share_arbiter_if.slave bus,
    output logic                busy
);
    import mult_ctrl_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t           state;
    grant_t               last_grant;
    grant_t               grant_q;
    grant_t               arb_gnt;
    logic                 arb_vld;
    logic                 accept;
    logic [CNT_W-1:0]     cnt;
    logic [OP_WIDTH-1:0]  a_q;
    logic [OP_WIDTH-1:0]  b_q;
    logic [RES_WIDTH-1:0] result_q;
    logic                 err_q;
    logic                 start_q;
    logic                 rsp0_q;
    logic                 rsp1_q;

    rr_arbiter2 u_rr (
        .req        ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant),
        .gnt_vld    (arb_vld),
        .gnt        (arb_gnt)
    );

    // Gated by reset so that ready reads 0 while reset is asserted.
    assign accept         = reset && (state == IDLE) && arb_vld;
    assign bus.req0_ready = accept && (arb_gnt == 1'b0);
    assign bus.req1_ready = accept && (arb_gnt == 1'b1);

    assign bus.mul_start  = start_q;
    assign bus.mul_a      = a_q;
    assign bus.mul_b      = b_q;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = err_q;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q        <= arb_gnt ? bus.req1_a : bus.req0_a;
                        b_q        <= arb_gnt ? bus.req1_b : bus.req0_b;
                        grant_q    <= arb_gnt;
                        last_grant <= arb_gnt;
                        cnt        <= '0;
                        start_q    <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Counts the first WAIT_DONE cycle as 1, so expiry lands after
                    // exactly TIMEOUT_CYCLES cycles spent waiting.
                    cnt   <= cnt + 1'b1;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.mul_done) begin
                        result_q <= bus.mul_result;
                        err_q    <= 1'b0;
                        rsp0_q   <= ~grant_q;
                        rsp1_q   <= grant_q;
                        state    <= RESPOND;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        rsp0_q   <= ~grant_q;
                        rsp1_q   <= grant_q;
                        state    <= RESPOND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: vector table, hand sequences for reset/stability, then randomized traffic vs a grant/result model.
module tb_mult_share_arbiter;

    localparam int TO = 8;

    typedef struct {
        bit          v0;
        bit          v1;
        logic [15:0] a0;
        logic [15:0] b0;
        logic [15:0] a1;
        logic [15:0] b1;
        int          lat;   // multiplier latency after start; 0 = never answers
        int          port;
        logic [31:0] res;
        bit          err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    mult_share_arbiter_if #(.OP_WIDTH(16), .RES_WIDTH(32)) bus ();

    mult_share_arbiter #(
        .OP_WIDTH       (16),
        .RES_WIDTH      (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_start = 0, n_rsp0 = 0, n_rsp1 = 0;
    int last_start_cyc = 0, last_rsp_cyc = 0;
    int mul_lat = 1;
    int mdl_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mul_start === 1'b1) begin
            n_start        <= n_start + 1;
            last_start_cyc <= cyc;
        end
        if (bus.rsp0_valid === 1'b1) begin
            n_rsp0       <= n_rsp0 + 1;
            last_rsp_cyc <= cyc;
        end
        if (bus.rsp1_valid === 1'b1) begin
            n_rsp1       <= n_rsp1 + 1;
            last_rsp_cyc <= cyc;
        end
    end

    // Multiplier core: answers a*b on a one-cycle done pulse mul_lat cycles after start.
    initial begin
        int          cd;
        logic [15:0] pa, pb;
        cd = -1;
        pa = '0;
        pb = '0;
        bus.mul_done   = 1'b0;
        bus.mul_result = '0;
        forever begin
            @(negedge clk);
            bus.mul_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.mul_done   = 1'b1;
                    bus.mul_result = 32'(pa) * 32'(pb);
                    cd = -1;
                end
            end
            if (bus.mul_start === 1'b1) begin
                pa = bus.mul_a;
                pb = bus.mul_b;
                cd = (mul_lat > 0) ? mul_lat : -1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (busy === 1'b1)
            chk("ready_while_busy", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
    endtask

    // Returns in the cycle after the transfer (ISSUE), with both valids dropped.
    task automatic wait_accept(output int port, output int acc_cyc);
        port    = -1;
        acc_cyc = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.req0_ready === 1'b1) port = 0;
            else if (bus.req1_ready === 1'b1) port = 1;
            if (port >= 0) begin
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int s0, r0, r1, port, acc, rp, exp_lat;
        s0 = n_start;
        r0 = n_rsp0;
        r1 = n_rsp1;
        tick();
        mul_lat        = v.lat;
        bus.req0_valid = v.v0;
        bus.req0_a     = v.a0;
        bus.req0_b     = v.b0;
        bus.req1_valid = v.v1;
        bus.req1_a     = v.a1;
        bus.req1_b     = v.b1;
        wait_accept(port, acc);
        #1;
        bus.req0_a = 16'($urandom);
        bus.req0_b = 16'($urandom);
        bus.req1_a = 16'($urandom);
        bus.req1_b = 16'($urandom);
        chk({tag, " accept_port"}, 64'(port), 64'(v.port));
        for (int k = 0; k < 30 && n_rsp0 == r0 && n_rsp1 == r1; k++) tick();
        rp = (n_rsp0 != r0) ? 0 : ((n_rsp1 != r1) ? 1 : -1);
        exp_lat = (v.lat >= 1 && v.lat <= TO) ? v.lat + 1 : TO + 1;
        chk({tag, " rsp_port"}, 64'(rp), 64'(v.port));
        chk({tag, " rsp_result"}, 64'(bus.rsp_result), 64'(v.res));
        chk({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(v.err));
        chk({tag, " accept_to_start"}, 64'(last_start_cyc - acc), 64'd1);
        chk({tag, " start_to_rsp"}, 64'(last_rsp_cyc - last_start_cyc), 64'(exp_lat));
        repeat (12) tick();
        chk({tag, " rsp_count"}, 64'((n_rsp0 - r0) + (n_rsp1 - r1)), 64'd1);
        chk({tag, " start_count"}, 64'(n_start - s0), 64'd1);
        chk({tag, " result_held"}, {31'd0, bus.rsp_err, bus.rsp_result}, {31'd0, v.err, v.res});
    endtask

    initial begin
        vec_t tbl [10];
        vec_t v;
        int   s0, r0, r1, port, acc, sel;
        logic [15:0] wa, wb;

        #100000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [10];
        vec_t v;
        int   s0, r0, r1, port, acc, sel;
        logic [15:0] wa, wb;

        //            v0 v1  a0        b0        a1        b1        lat port res            err
        tbl[0] = '{1'b1, 1'b1, 16'h0002, 16'h0007, 16'h0009, 16'h0009, 1,  0, 32'h0000_000E, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 16'h0010, 16'h0010, 16'h0011, 16'h0003, 2,  1, 32'h0000_0033, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0005, 16'h0005, 3,  0, 32'h0001_0000, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 3,  0, 32'h0000_000F, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1234, 16'h0010, TO, 1, 32'h0001_2340, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'hBEEF, 16'h0002, 16'h0000, 16'h0000, 0,  0, 32'h0000_0000, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 5,  1, 32'hFFFE_0001, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 16'h0007, 16'h0008, 16'h0009, 16'h000A, 9,  0, 32'h0000_0000, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 16'h0003, 16'h0003, 16'h0004, 16'h0004, 10, 1, 32'h0000_0000, 1'b1};
        tbl[9] = '{1'b1, 1'b1, 16'h00AB, 16'h00CD, 16'h0001, 16'h0001, 4,  0, 32'h0000_88EF, 1'b0};

        reset = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        tick();
        tick();
        bus.req0_valid = 1'b1;
        #1;
        chk("reset_ctrl", {57'd0, busy, bus.req0_ready, bus.req1_ready, bus.mul_start,
                           bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err}, 64'd0);
        chk("reset_result", 64'(bus.rsp_result), 64'd0);
        chk("reset_operands", {32'd0, bus.mul_a, bus.mul_b}, 64'd0);
        bus.req0_valid = 1'b0;
        tick();
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

        // Reset while waiting for a multiplier that never answers.
        s0 = n_start;
        tick();
        mul_lat = 0;
        bus.req0_valid = 1'b1;
        bus.req0_a = 16'h1111;
        bus.req0_b = 16'h0002;
        wait_accept(port, acc);
        chk("rstmid accept_port", 64'(port), 64'd0);
        repeat (4) tick();
        chk("rstmid busy_before", 64'(busy), 64'd1);
        chk("rstmid result_before", 64'(bus.rsp_result), 64'h88EF);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid async_ctrl", {59'd0, busy, bus.mul_start, bus.rsp0_valid, bus.rsp1_valid,
                                  bus.rsp_err}, 64'd0);
        chk("rstmid async_result", 64'(bus.rsp_result), 64'd0);
        chk("rstmid async_operands", {32'd0, bus.mul_a, bus.mul_b}, 64'd0);
        r0 = n_rsp0;
        r1 = n_rsp1;
        tick();
        tick();
        reset = 1'b1;
        repeat (12) tick();
        chk("rstmid no_rsp", 64'((n_rsp0 - r0) + (n_rsp1 - r1)), 64'd0);
        chk("rstmid start_count", 64'(n_start - s0), 64'd1);
        v = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 6, 1, 32'hFFFE_0001, 1'b0};
        run_txn("post_reset", v);

        // Operands must stay latched while requesters churn their inputs.
        s0 = n_start;
        r0 = n_rsp0;
        r1 = n_rsp1;
        tick();
        mul_lat = 6;
        bus.req0_valid = 1'b1;
        bus.req0_a = 16'h0042;
        bus.req0_b = 16'h0003;
        wait_accept(port, acc);
        chk("stable accept_port", 64'(port), 64'd0);
        for (int k = 0; k < 8; k++) begin
            chk("stable mul_ab", {32'd0, bus.mul_a, bus.mul_b}, {32'd0, 16'h0042, 16'h0003});
            bus.req0_a = 16'($urandom);
            bus.req0_b = 16'($urandom);
            bus.req1_valid = (k % 3 == 2);
            tick();
        end
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 20 && n_rsp0 == r0 && n_rsp1 == r1; k++) tick();
        chk("stable rsp", {31'd0, bus.rsp_err, bus.rsp_result}, {31'd0, 1'b0, 32'h0000_00C6});
        repeat (12) tick();
        chk("stable rsp0_count", 64'(n_rsp0 - r0), 64'd1);
        chk("stable rsp1_count", 64'(n_rsp1 - r1), 64'd0);
        chk("stable start_count", 64'(n_start - s0), 64'd1);

        // Randomized traffic: winner from the round-robin rule, product or timeout from latency.
        mdl_last = 0;
        for (int i = 0; i < 30; i++) begin
            sel  = $urandom_range(1, 3);
            v.v0 = sel[0];
            v.v1 = sel[1];
            v.a0 = 16'($urandom);
            v.b0 = 16'($urandom);
            v.a1 = 16'($urandom);
            v.b1 = 16'($urandom);
            v.lat = $urandom_range(0, 10);
            if (v.v0 && v.v1) v.port = (mdl_last == 0) ? 1 : 0;
            else              v.port = v.v0 ? 0 : 1;
            mdl_last = v.port;
            wa = (v.port == 0) ? v.a0 : v.a1;
            wb = (v.port == 0) ? v.b0 : v.b1;
            v.err = !(v.lat >= 1 && v.lat <= TO);
            v.res = v.err ? 32'd0 : 32'(wa) * 32'(wb);
            run_txn($sformatf("rand%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
